rr_arb_8: RTL and testbench
===========================

RR_ARB_8 -- requirements
Module: rr_arb_8

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 16, max consecutive grant cycles per owner (legal 2..255).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req  input  8  per-requester request, bit i = requester i.
REQ-005 SHALL have port: done  input  1  owner finished; valid only while gnt_valid=1.
REQ-006 SHALL have port: gnt  output  8  one-hot grant, registered.
REQ-007 SHALL have port: gnt_id  output  3  binary index of owner, registered.
REQ-008 SHALL have port: gnt_valid  output  1  high while any grant is active.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
REQ-010 SHALL use one clock (clk) with a synchronous, active-high reset (rst).

Function
REQ-011 SHALL implement FSM states IDLE and OWN; no other states.
REQ-012 SHALL keep pointer last_id[2:0] = index of most recent owner.
REQ-013 SHALL arbitrate in IDLE: masked = req AND bits strictly below last_id; winner = highest set bit of masked if non-zero, else highest set bit of req.
REQ-014 SHALL, in IDLE with req != 0 at edge N, set gnt/gnt_id/gnt_valid at edge N (visible cycle N+1), load last_id = winner, clear hold_cnt, enter OWN.
REQ-015 SHALL remain in IDLE with gnt=0, gnt_valid=0 and gnt_id held when req == 0.
REQ-016 SHALL, in OWN, keep gnt constant and increment hold_cnt every cycle.
REQ-017 SHALL leave OWN -> IDLE on the edge where any holds: done=1, req[gnt_id]=0, or hold_cnt == MAX_HOLD-1.
REQ-018 SHALL deassert gnt and gnt_valid on that same edge; at least one idle cycle separates consecutive grants.
REQ-019 SHALL pulse timeout for exactly one cycle only when exit is caused solely by hold_cnt == MAX_HOLD-1 (done=0, req[gnt_id]=1).
REQ-020 SHALL ignore requests from non-owners while in OWN; they are serviced by the next IDLE arbitration.
REQ-021 SHALL ignore done while in IDLE.
REQ-022 SHALL guarantee gnt is one-hot or zero in every cycle, and gnt[gnt_id] == gnt_valid.
REQ-023 SHALL size hold_cnt at 8 bits with no wrap: it never exceeds MAX_HOLD-1.
REQ-024 SHALL give a single requester held high consecutive grants separated by one idle cycle each.

Reset
REQ-025 SHALL, when rst=1 at an edge, force state=IDLE, gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, hold_cnt=0, last_id=3'd0, regardless of state.
REQ-026 SHALL make reset mid-grant drop gnt at that edge without pulsing timeout.
REQ-027 SHALL give first post-reset arbitration to the highest-index requester (masked set is empty when last_id=0).

Structure
REQ-028 SHALL place the FSM state enum (IDLE, OWN) and the constant N_REQ=8 in shared package arb_pkg.
REQ-029 SHALL instantiate sub-module prio_enc_8 twice (masked, unmasked): combinational, 8-bit in, 3-bit index plus valid out, highest-set-bit priority.
REQ-030 SHALL keep all outputs driven directly from flops.

Verification
REQ-031 SHALL cover: reset, then req=8'h81 -> gnt=8'h80, gnt_id=7 one cycle later.
REQ-032 SHALL cover: req=8'hFF held, done pulsed each grant -> owners 7,6,5,4,3,2,1,0,7 in order, one idle cycle between grants.
REQ-033 SHALL cover: req=8'h04 held, done=0, MAX_HOLD=16 -> gnt=8'h04 for exactly 16 cycles, timeout pulse on the 16th-cycle edge, regrant after one idle cycle.
REQ-034 SHALL cover: owner 5 drops req[5] while req[2] high -> gnt=0 next cycle, then gnt=8'h04.
REQ-035 SHALL cover: rst asserted during OWN with gnt=8'h10 -> all outputs zero next cycle, next req=8'h11 grants 4.
REQ-036 SHALL cover: done and hold_cnt limit coincide -> exit to IDLE, timeout stays 0; a random-stimulus checker confirms gnt is one-hot or zero every cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the 8-way round-robin arbiter
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   // Bits strictly below the given index; these win the next round-robin pass.
   function automatic logic [N_REQ-1:0] below_mask(input logic [ID_W-1:0] id);
      logic [N_REQ-1:0] m;
      for (int i = 0; i < N_REQ; i++) begin
         m[i] = (ID_W'(i) < id);
      end
      return m;
   endfunction

endpackage

// File: rtl/prio_enc_8.sv
// rtl/prio_enc_8.sv - 8-bit highest-set-bit priority encoder
module prio_enc_8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] vec_i,
   output logic [ID_W-1:0]  idx_o,
   output logic             valid_o
);

   // Ascending scan so the highest set bit is the last assignment to land.
   always_comb begin
      idx_o   = '0;
      valid_o = |vec_i;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec_i[i]) idx_o = ID_W'(i);
      end
   end

endmodule

// File: rtl/rr_arb_8.sv
// rtl/rr_arb_8.sv - 8-requester round-robin arbiter with hold-time limit
module rr_arb_8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             timeout_q, timeout_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic [ID_W-1:0]  last_id_q, last_id_d;

   logic [ID_W-1:0]  m_idx, u_idx, win_idx;
   logic             m_valid, u_valid;
   logic             at_limit, owner_drop, exit_own;

   prio_enc_8 u_enc_masked (
      .vec_i   (req & below_mask(last_id_q)),
      .idx_o   (m_idx),
      .valid_o (m_valid)
   );

   prio_enc_8 u_enc_all (
      .vec_i   (req),
      .idx_o   (u_idx),
      .valid_o (u_valid)
   );

   assign win_idx    = m_valid ? m_idx : u_idx;
   assign at_limit   = (hold_cnt_q == HOLD_LIM);
   assign owner_drop = ~req[gnt_id_q];
   assign exit_own   = done | owner_drop | at_limit;

   // State and all output/bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
         last_id_q   <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         last_id_q   <= last_id_d;
      end
   end

   // Next-state: grant on any request, release on done/drop/hold limit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (u_valid)  state_d = OWN;
         OWN:     if (exit_own) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next values; timeout only when the hold limit is the sole cause.
   always_comb begin
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      last_id_d   = last_id_q;
      case (state_q)
         IDLE: begin
            if (u_valid) begin
               gnt_d       = N_REQ'(1) << win_idx;
               gnt_id_d    = win_idx;
               gnt_valid_d = 1'b1;
               last_id_d   = win_idx;
               hold_cnt_d  = '0;
            end else begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
            end
         end
         OWN: begin
            if (exit_own) begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
               timeout_d   = at_limit & ~done & ~owner_drop;
            end else begin
               hold_cnt_d  = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb_8.sv
// tb/tb_rr_arb_8.sv - directed and random checks for rr_arb_8
module tb_rr_arb_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int compared   = 0;
   int mismatched = 0;

   rr_arb_8 #(.MAX_HOLD(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] id);
      chk({tag, ".gnt"}, {24'd0, gnt}, 32'd1 << id);
      chk({tag, ".id"}, {29'd0, gnt_id}, {29'd0, id});
      chk({tag, ".valid"}, {31'd0, gnt_valid}, 32'd1);
   endtask

   task automatic chk_idle(input string tag, input logic exp_to);
      chk({tag, ".gnt"}, {24'd0, gnt}, 32'd0);
      chk({tag, ".valid"}, {31'd0, gnt_valid}, 32'd0);
      chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, exp_to});
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 8'h00; done = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [2:0] order [9];
      order = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

      // Reset state
      do_reset();
      step();
      chk_idle("reset", 1'b0);
      chk("reset.id", {29'd0, gnt_id}, 32'd0);

      // First arbitration after reset goes to the highest requester
      req = 8'h81;
      step();
      chk_grant("first81", 3'd7);
      done = 1'b1;
      step();
      chk_idle("done_exit", 1'b0);
      chk("idle_id_held", {29'd0, gnt_id}, 32'd7);
      done = 1'b1; req = 8'h00;
      step();
      chk_idle("done_in_idle", 1'b0);
      done = 1'b0;

      // Full rotation with done pulsed each grant
      do_reset();
      req = 8'hFF;
      step();
      for (int k = 0; k < 9; k++) begin
         chk_grant($sformatf("rot%0d", k), order[k]);
         done = 1'b1;
         step();
         chk_idle($sformatf("rot_gap%0d", k), 1'b0);
         done = 1'b0;
         step();
      end
      req = 8'h00;
      step();
      chk_idle("rot_end", 1'b0);

      // Hold limit: 16 grant cycles, timeout pulse, regrant after one idle
      do_reset();
      req = 8'h04;
      step();
      chk_grant("hold1", 3'd2);
      for (int c = 2; c <= 16; c++) begin
         step();
         chk($sformatf("hold%0d.gnt", c), {24'd0, gnt}, 32'h04);
         chk($sformatf("hold%0d.to", c), {31'd0, timeout}, 32'd0);
      end
      step();
      chk_idle("hold_timeout", 1'b1);
      step();
      chk_grant("hold_regrant", 3'd2);
      chk("hold_to_clear", {31'd0, timeout}, 32'd0);
      req = 8'h00;
      step();
      chk_idle("hold_drop", 1'b0);

      // Owner 5 drops its request while 2 is waiting
      req = 8'h24;
      step();
      chk_grant("own5", 3'd5);
      req = 8'h04;
      step();
      chk_idle("own5_drop", 1'b0);
      step();
      chk_grant("then2", 3'd2);
      req = 8'h00;
      step();

      // Reset mid-grant
      do_reset();
      req = 8'h10;
      step();
      chk_grant("pre_rst", 3'd4);
      rst = 1'b1;
      step();
      chk_idle("mid_rst", 1'b0);
      chk("mid_rst.id", {29'd0, gnt_id}, 32'd0);
      rst = 1'b0; req = 8'h11;
      step();
      chk_grant("post_rst11", 3'd4);
      req = 8'h00;
      step();

      // done coincides with the hold limit: no timeout
      do_reset();
      req = 8'h04;
      step();
      for (int c = 0; c < 15; c++) step();
      chk("coinc_still", {24'd0, gnt}, 32'h04);
      done = 1'b1;
      step();
      chk_idle("coinc_exit", 1'b0);
      done = 1'b0; req = 8'h00;
      step();

      // Random stimulus: grant structure invariants every cycle
      for (int r = 0; r < 300; r++) begin
         req  = 8'($urandom);
         done = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 63) == 0);
         step();
         chk("rnd_onehot", {31'd0, ((gnt & (gnt - 8'd1)) == 8'd0)}, 32'd1);
         chk("rnd_valid", {31'd0, gnt[gnt_id]}, {31'd0, gnt_valid});
         chk("rnd_nz", {31'd0, (gnt != 8'd0)}, {31'd0, gnt_valid});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
